na_read_arbiter: RTL and testbench

- Shares one debug-side flit buffer between NUM_REQ NoC-adapter read FSMs.
- Each FSM raises req when it has an IRQ pending and the buffer is empty. It starts reading only after its enable is asserted.
- The arbiter grants enable round-robin and locks the grant for a whole packet. It muxes the granted FSM's flit signals onto the buffer.
- It terminates stalled or abandoned packets so the buffer never holds a half packet.

---
 rtl/na_read_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_na_read_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/na_read_arbiter.sv
// Round-robin read arbiter: shares one debug-side flit buffer between NUM_REQ
// NoC-adapter read FSMs, locking the grant for a packet and closing broken packets.
module na_read_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int NOC_FLIT_WIDTH = 32,
    parameter int HDR_TIMEOUT    = 64,
    parameter int PKT_TIMEOUT    = 256
) (
    input  logic                              clk,
    input  logic                              rst_debug_n,
    input  logic                              arb_en,
    input  logic [NUM_REQ-1:0]                req_i,
    output logic [NUM_REQ-1:0]                enable_o,
    input  logic [NUM_REQ*NOC_FLIT_WIDTH-1:0] flit_data_i,
    input  logic [NUM_REQ-1:0]                flit_valid_i,
    input  logic [NUM_REQ-1:0]                flit_last_i,
    input  logic [NUM_REQ-1:0]                flit_16_i,
    output logic [NOC_FLIT_WIDTH-1:0]         out_flit_data,
    output logic                              out_flit_valid,
    output logic                              out_flit_last,
    output logic                              out_flit_16,
    output logic [$clog2(NUM_REQ)-1:0]        grant_id,
    output logic                              busy,
    output logic                              proto_err,
    output logic [2:0]                        state_dbg_o
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int TMAX = (HDR_TIMEOUT > PKT_TIMEOUT) ? HDR_TIMEOUT : PKT_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0]   HDR_LIMIT = TW'(HDR_TIMEOUT - 1);
    localparam logic [TW-1:0]   PKT_LIMIT = TW'(PKT_TIMEOUT - 1);
    localparam logic [TW-1:0]   TIMER_MAX = '1;
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);
    localparam logic [ID_W:0]   NUM_REQ_W = (ID_W + 1)'(NUM_REQ);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GRANT  = 3'd1,
        S_PACKET = 3'd2,
        S_TERM   = 3'd3,
        S_GAP    = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     grant_id_q, grant_id_d;
    logic [NUM_REQ-1:0]  enable_q, enable_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                proto_err_q, proto_err_d;

    logic                rr_found;
    logic [ID_W-1:0]     rr_pick;
    logic [ID_W:0]       rr_sum;
    logic [ID_W-1:0]     rr_cand;

    logic [NOC_FLIT_WIDTH-1:0] g_data;
    logic                g_valid;
    logic                g_last;
    logic                g_16;
    logic                g_req;
    logic                intrude;
    logic [TW-1:0]       timer_inc;

    // Flit handshake: a flit transfers on every cycle its valid is high while
    // the sender holds enable; there is no backpressure toward the FSMs.

    // Round-robin pick: first requester strictly after grant_id, wrapping.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = grant_id_q;
        rr_sum   = '0;
        rr_cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            rr_sum = {1'b0, grant_id_q} + (ID_W + 1)'(i);
            if (rr_sum >= NUM_REQ_W) begin
                rr_sum = rr_sum - NUM_REQ_W;
            end
            rr_cand = rr_sum[ID_W-1:0];
            if (!rr_found && req_i[rr_cand]) begin
                rr_found = 1'b1;
                rr_pick  = rr_cand;
            end
        end
    end

    // Grantee's view of the shared inputs.
    always_comb begin
        g_data  = '0;
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_16    = 1'b0;
        g_req   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == ID_W'(i)) begin
                g_data  = flit_data_i[i*NOC_FLIT_WIDTH +: NOC_FLIT_WIDTH];
                g_valid = flit_valid_i[i];
                g_last  = flit_last_i[i];
                g_16    = flit_16_i[i];
                g_req   = req_i[i];
            end
        end
    end

    // enable_q is zero outside GRANT/PACKET, so any valid it does not cover is an intrusion.
    assign intrude   = |(flit_valid_i & ~enable_q);
    assign timer_inc = (timer_q == TIMER_MAX) ? timer_q : timer_q + TW'(1);

    always_ff @(posedge clk) begin
        if (!rst_debug_n) begin
            state_q     <= S_IDLE;
            grant_id_q  <= LAST_ID;
            enable_q    <= '0;
            timer_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_id_q  <= grant_id_d;
            enable_q    <= enable_d;
            timer_q     <= timer_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_id_d  = grant_id_q;
        timer_d     = timer_q;
        proto_err_d = proto_err_q | intrude;
        enable_d    = '0;
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (arb_en && rr_found) begin
                    state_d    = S_GRANT;
                    grant_id_d = rr_pick;
                end
            end
            S_GRANT: begin
                if (g_valid) begin
                    timer_d = '0;
                    state_d = g_last ? S_GAP : S_PACKET;
                end else if (!g_req) begin
                    state_d = S_GAP;
                end else if (timer_q >= HDR_LIMIT) begin
                    state_d = S_GAP;
                end else begin
                    timer_d = timer_inc;
                end
            end
            S_PACKET: begin
                // A flit always wins over a concurrent req drop or timeout.
                if (g_valid) begin
                    timer_d = '0;
                    if (g_last) begin
                        state_d = S_GAP;
                    end
                end else if (!g_req || (timer_q >= PKT_LIMIT)) begin
                    state_d     = S_TERM;
                    proto_err_d = 1'b1;
                end else begin
                    timer_d = timer_inc;
                end
            end
            S_TERM: begin
                timer_d = '0;
                state_d = S_GAP;
            end
            S_GAP: begin
                timer_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                timer_d = '0;
                state_d = S_IDLE;
            end
        endcase
        if (state_d == S_GRANT || state_d == S_PACKET) begin
            enable_d[grant_id_d] = 1'b1;
        end
    end

    always_comb begin
        out_flit_data  = '0;
        out_flit_valid = 1'b0;
        out_flit_last  = 1'b0;
        out_flit_16    = 1'b0;
        case (state_q)
            S_GRANT, S_PACKET: begin
                out_flit_data  = g_data;
                out_flit_valid = g_valid;
                out_flit_last  = g_last;
                out_flit_16    = g_16;
            end
            S_TERM: begin
                out_flit_valid = 1'b1;
                out_flit_last  = 1'b1;
            end
            default: begin
                out_flit_valid = 1'b0;
            end
        endcase
    end

    assign enable_o    = enable_q;
    assign grant_id    = grant_id_q;
    assign busy        = (state_q != S_IDLE);
    assign proto_err   = proto_err_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_na_read_arbiter.sv
// Directed bench for na_read_arbiter: grant order, packet forwarding,
// timeouts, forced termination, intrusion and reset behaviour.
module tb_na_read_arbiter;

    localparam int N = 4;
    localparam int W = 32;
    localparam int HDR = 64;
    localparam int PKT = 256;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_GRANT  = 3'd1;
    localparam logic [2:0] ST_PACKET = 3'd2;
    localparam logic [2:0] ST_TERM   = 3'd3;
    localparam logic [2:0] ST_GAP    = 3'd4;

    logic           clk = 1'b0;
    logic           rst_debug_n;
    logic           arb_en;
    logic [N-1:0]   req_i;
    logic [N-1:0]   enable_o;
    logic [N*W-1:0] flit_data_i;
    logic [N-1:0]   flit_valid_i;
    logic [N-1:0]   flit_last_i;
    logic [N-1:0]   flit_16_i;
    logic [W-1:0]   out_flit_data;
    logic           out_flit_valid;
    logic           out_flit_last;
    logic           out_flit_16;
    logic [1:0]     grant_id;
    logic           busy;
    logic           proto_err;
    logic [2:0]     state_dbg_o;

    int pass_cnt = 0;
    int check_cnt = 0;

    na_read_arbiter #(
        .NUM_REQ(N), .NOC_FLIT_WIDTH(W), .HDR_TIMEOUT(HDR), .PKT_TIMEOUT(PKT)
    ) dut (
        .clk(clk), .rst_debug_n(rst_debug_n), .arb_en(arb_en), .req_i(req_i),
        .enable_o(enable_o), .flit_data_i(flit_data_i), .flit_valid_i(flit_valid_i),
        .flit_last_i(flit_last_i), .flit_16_i(flit_16_i), .out_flit_data(out_flit_data),
        .out_flit_valid(out_flit_valid), .out_flit_last(out_flit_last),
        .out_flit_16(out_flit_16), .grant_id(grant_id), .busy(busy),
        .proto_err(proto_err), .state_dbg_o(state_dbg_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flit(input int idx, input logic v, input logic l, input logic s, input logic [W-1:0] d);
        flit_valid_i[idx] = v;
        flit_last_i[idx] = l;
        flit_16_i[idx] = s;
        flit_data_i[idx*W +: W] = d;
    endtask

    task automatic clear_flits();
        flit_valid_i = '0;
        flit_last_i = '0;
        flit_16_i = '0;
        flit_data_i = '0;
    endtask

    task automatic do_reset();
        rst_debug_n = 1'b0;
        arb_en = 1'b1;
        req_i = '0;
        clear_flits();
        tick();
        tick();
        rst_debug_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_debug_n = 1'b0;
        arb_en = 1'b1;
        req_i = 4'b1111;
        clear_flits();
        tick();
        #1;
        check_cnt++; if (state_dbg_o !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", state_dbg_o, ST_IDLE); else pass_cnt++;
        check_cnt++; if (enable_o !== 4'b0000) $display("FAIL reset_enable: got %b want 0000", enable_o); else pass_cnt++;
        check_cnt++; if (grant_id !== 2'd3) $display("FAIL reset_grant_id: got %0d want 3", grant_id); else pass_cnt++;
        check_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        check_cnt++; if (proto_err !== 1'b0) $display("FAIL reset_proto_err: got %b want 0", proto_err); else pass_cnt++;
        check_cnt++; if ({out_flit_valid, out_flit_last, out_flit_16, out_flit_data} !== '0) $display("FAIL reset_out_flit: got v%b l%b s%b d%h want all 0", out_flit_valid, out_flit_last, out_flit_16, out_flit_data); else pass_cnt++;
        rst_debug_n = 1'b1;
        req_i = '0;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        req_i = 4'b0001;
        #1;
        check_cnt++; if (enable_o !== 4'b0000) $display("FAIL single_en_before: got %b want 0000", enable_o); else pass_cnt++;
        tick();
        check_cnt++; if (enable_o !== 4'b0001) $display("FAIL single_en_grant: got %b want 0001", enable_o); else pass_cnt++;
        check_cnt++; if (grant_id !== 2'd0) $display("FAIL single_grant_id: got %0d want 0", grant_id); else pass_cnt++;
        set_flit(0, 1'b1, 1'b0, 1'b1, 32'hA1A1_0001);
        #1;
        check_cnt++; if (out_flit_data !== 32'hA1A1_0001 || out_flit_valid !== 1'b1 || out_flit_16 !== 1'b1 || out_flit_last !== 1'b0) $display("FAIL single_hdr: got d%h v%b s%b l%b want dA1A10001 v1 s1 l0", out_flit_data, out_flit_valid, out_flit_16, out_flit_last); else pass_cnt++;
        tick();
        check_cnt++; if (state_dbg_o !== ST_PACKET) $display("FAIL single_packet_state: got %0d want %0d", state_dbg_o, ST_PACKET); else pass_cnt++;
        set_flit(0, 1'b1, 1'b0, 1'b0, 32'hA2A2_0002);
        #1;
        check_cnt++; if (out_flit_data !== 32'hA2A2_0002 || out_flit_16 !== 1'b0) $display("FAIL single_flit2: got d%h s%b want dA2A20002 s0", out_flit_data, out_flit_16); else pass_cnt++;
        tick();
        set_flit(0, 1'b1, 1'b0, 1'b0, 32'hA3A3_0003);
        #1;
        check_cnt++; if (out_flit_data !== 32'hA3A3_0003) $display("FAIL single_flit3: got %h want A3A30003", out_flit_data); else pass_cnt++;
        tick();
        // Last flit arrives together with the req drop: a normal end.
        set_flit(0, 1'b1, 1'b1, 1'b0, 32'hA4A4_0004);
        req_i = 4'b0000;
        #1;
        check_cnt++; if (out_flit_data !== 32'hA4A4_0004 || out_flit_last !== 1'b1) $display("FAIL single_last: got d%h l%b want dA4A40004 l1", out_flit_data, out_flit_last); else pass_cnt++;
        tick();
        clear_flits();
        #1;
        check_cnt++; if (state_dbg_o !== ST_GAP || enable_o !== 4'b0000) $display("FAIL single_gap: got st%0d en%b want st%0d en0000", state_dbg_o, enable_o, ST_GAP); else pass_cnt++;
        tick();
        check_cnt++; if (state_dbg_o !== ST_IDLE || busy !== 1'b0) $display("FAIL single_idle: got st%0d busy%b want st0 busy0", state_dbg_o, busy); else pass_cnt++;
        check_cnt++; if (proto_err !== 1'b0) $display("FAIL single_proto_err: got %b want 0", proto_err); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        logic [N-1:0] exp_en;
        do_reset();
        req_i = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_en = 4'(1) << order[k];
            tick();
            check_cnt++; if (grant_id !== 2'(order[k]) || enable_o !== exp_en || state_dbg_o !== ST_GRANT) $display("FAIL rr_grant_%0d: got id%0d en%b st%0d want id%0d en%b st%0d", k, grant_id, enable_o, state_dbg_o, order[k], exp_en, ST_GRANT); else pass_cnt++;
            set_flit(order[k], 1'b1, 1'b0, 1'b0, 32'h100 + k);
            tick();
            set_flit(order[k], 1'b1, 1'b1, 1'b0, 32'h200 + k);
            #1;
            check_cnt++; if (out_flit_data !== 32'h200 + k || out_flit_last !== 1'b1) $display("FAIL rr_last_%0d: got d%h l%b want d%h l1", k, out_flit_data, out_flit_last, 32'h200 + k); else pass_cnt++;
            tick();
            clear_flits();
            check_cnt++; if (state_dbg_o !== ST_GAP || enable_o !== 4'b0000) $display("FAIL rr_gap_%0d: got st%0d en%b want st%0d en0000", k, state_dbg_o, enable_o, ST_GAP); else pass_cnt++;
            tick();
            check_cnt++; if (state_dbg_o !== ST_IDLE) $display("FAIL rr_idle_%0d: got st%0d want st0", k, state_dbg_o); else pass_cnt++;
        end
        req_i = 4'b0000;
        tick();
        check_cnt++; if (proto_err !== 1'b0) $display("FAIL rr_proto_err: got %b want 0", proto_err); else pass_cnt++;
    endtask

    task automatic test_empty_grant();
        do_reset();
        req_i = 4'b1100;
        tick();
        check_cnt++; if (grant_id !== 2'd2 || state_dbg_o !== ST_GRANT) $display("FAIL empty_grant2: got id%0d st%0d want id2 st%0d", grant_id, state_dbg_o, ST_GRANT); else pass_cnt++;
        repeat (HDR - 1) tick();
        check_cnt++; if (state_dbg_o !== ST_GRANT || enable_o !== 4'b0100) $display("FAIL empty_hold_63: got st%0d en%b want st%0d en0100", state_dbg_o, enable_o, ST_GRANT); else pass_cnt++;
        tick();
        check_cnt++; if (state_dbg_o !== ST_GAP || enable_o !== 4'b0000) $display("FAIL empty_revoke_64: got st%0d en%b want st%0d en0000", state_dbg_o, enable_o, ST_GAP); else pass_cnt++;
        tick();
        tick();
        check_cnt++; if (grant_id !== 2'd3 || enable_o !== 4'b1000) $display("FAIL empty_next_grant: got id%0d en%b want id3 en1000", grant_id, enable_o); else pass_cnt++;
        req_i = 4'b0000;
        tick();
        check_cnt++; if (state_dbg_o !== ST_GAP) $display("FAIL empty_req_drop: got st%0d want st%0d", state_dbg_o, ST_GAP); else pass_cnt++;
        check_cnt++; if (proto_err !== 1'b0) $display("FAIL empty_proto_err: got %b want 0", proto_err); else pass_cnt++;
        tick();
    endtask

    task automatic test_abandoned();
        do_reset();
        req_i = 4'b0010;
        tick();
        set_flit(1, 1'b1, 1'b0, 1'b0, 32'h0000_0011);
        tick();
        set_flit(1, 1'b1, 1'b0, 1'b0, 32'h0000_0012);
        tick();
        check_cnt++; if (proto_err !== 1'b0) $display("FAIL abandon_no_err_yet: got %b want 0", proto_err); else pass_cnt++;
        set_flit(1, 1'b0, 1'b1, 1'b1, 32'hFFFF_0013);
        req_i = 4'b0000;
        tick();
        check_cnt++; if (state_dbg_o !== ST_TERM || enable_o !== 4'b0000) $display("FAIL abandon_term_state: got st%0d en%b want st%0d en0000", state_dbg_o, enable_o, ST_TERM); else pass_cnt++;
        check_cnt++; if (out_flit_valid !== 1'b1 || out_flit_last !== 1'b1 || out_flit_data !== 32'h0 || out_flit_16 !== 1'b0) $display("FAIL abandon_term_flit: got v%b l%b d%h s%b want v1 l1 d0 s0", out_flit_valid, out_flit_last, out_flit_data, out_flit_16); else pass_cnt++;
        check_cnt++; if (proto_err !== 1'b1) $display("FAIL abandon_proto_err: got %b want 1", proto_err); else pass_cnt++;
        tick();
        check_cnt++; if (state_dbg_o !== ST_GAP || out_flit_valid !== 1'b0) $display("FAIL abandon_gap: got st%0d v%b want st%0d v0", state_dbg_o, out_flit_valid, ST_GAP); else pass_cnt++;
        clear_flits();
        tick();
    endtask

    task automatic test_intrusion();
        do_reset();
        req_i = 4'b0001;
        tick();
        set_flit(0, 1'b1, 1'b0, 1'b0, 32'h0000_000A);
        set_flit(3, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
        #1;
        check_cnt++; if (out_flit_data !== 32'h0000_000A) $display("FAIL intrude_not_fwd: got %h want 0000000A", out_flit_data); else pass_cnt++;
        tick();
        check_cnt++; if (proto_err !== 1'b1 || state_dbg_o !== ST_PACKET) $display("FAIL intrude_err: got err%b st%0d want err1 st%0d", proto_err, state_dbg_o, ST_PACKET); else pass_cnt++;
        set_flit(3, 1'b0, 1'b0, 1'b0, 32'h0);
        set_flit(0, 1'b1, 1'b1, 1'b0, 32'h0000_000B);
        tick();
        check_cnt++; if (state_dbg_o !== ST_GAP) $display("FAIL intrude_end: got st%0d want st%0d", state_dbg_o, ST_GAP); else pass_cnt++;
        clear_flits();
        req_i = 4'b0000;
        tick();
    endtask

    task automatic test_stall();
        do_reset();
        req_i = 4'b0001;
        tick();
        set_flit(0, 1'b1, 1'b0, 1'b0, 32'h0000_0051);
        tick();
        set_flit(0, 1'b0, 1'b0, 1'b0, 32'h0000_0052);
        repeat (100) tick();
        // A mid-packet flit restarts the inter-flit timer.
        set_flit(0, 1'b1, 1'b0, 1'b0, 32'h0000_0053);
        tick();
        set_flit(0, 1'b0, 1'b0, 1'b0, 32'h0000_0054);
        repeat (PKT - 1) tick();
        check_cnt++; if (state_dbg_o !== ST_PACKET || proto_err !== 1'b0) $display("FAIL stall_hold_255: got st%0d err%b want st%0d err0", state_dbg_o, proto_err, ST_PACKET); else pass_cnt++;
        tick();
        check_cnt++; if (state_dbg_o !== ST_TERM || out_flit_valid !== 1'b1 || out_flit_last !== 1'b1 || out_flit_data !== 32'h0) $display("FAIL stall_term: got st%0d v%b l%b d%h want st%0d v1 l1 d0", state_dbg_o, out_flit_valid, out_flit_last, out_flit_data, ST_TERM); else pass_cnt++;
        check_cnt++; if (proto_err !== 1'b1) $display("FAIL stall_proto_err: got %b want 1", proto_err); else pass_cnt++;
        tick();
        req_i = 4'b0000;
        clear_flits();
        tick();
    endtask

    task automatic test_arb_en();
        do_reset();
        arb_en = 1'b0;
        req_i = 4'b0001;
        tick();
        tick();
        check_cnt++; if (state_dbg_o !== ST_IDLE || enable_o !== 4'b0000) $display("FAIL arb_en_block: got st%0d en%b want st0 en0000", state_dbg_o, enable_o); else pass_cnt++;
        arb_en = 1'b1;
        tick();
        check_cnt++; if (state_dbg_o !== ST_GRANT || enable_o !== 4'b0001) $display("FAIL arb_en_grant: got st%0d en%b want st%0d en0001", state_dbg_o, enable_o, ST_GRANT); else pass_cnt++;
        arb_en = 1'b0;
        set_flit(0, 1'b1, 1'b1, 1'b0, 32'h0000_0077);
        #1;
        check_cnt++; if (out_flit_valid !== 1'b1 || out_flit_data !== 32'h0000_0077) $display("FAIL arb_en_midgrant: got v%b d%h want v1 d00000077", out_flit_valid, out_flit_data); else pass_cnt++;
        tick();
        check_cnt++; if (state_dbg_o !== ST_GAP) $display("FAIL arb_en_single_flit: got st%0d want st%0d", state_dbg_o, ST_GAP); else pass_cnt++;
        clear_flits();
        req_i = 4'b0000;
        arb_en = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        req_i = 4'b0001;
        tick();
        set_flit(0, 1'b1, 1'b0, 1'b0, 32'h0000_0061);
        tick();
        check_cnt++; if (state_dbg_o !== ST_PACKET) $display("FAIL rstmid_in_packet: got st%0d want st%0d", state_dbg_o, ST_PACKET); else pass_cnt++;
        rst_debug_n = 1'b0;
        req_i = 4'b0011;
        tick();
        check_cnt++; if (state_dbg_o !== ST_IDLE || enable_o !== 4'b0000 || busy !== 1'b0 || grant_id !== 2'd3) $display("FAIL rstmid_regs: got st%0d en%b busy%b id%0d want st0 en0000 busy0 id3", state_dbg_o, enable_o, busy, grant_id); else pass_cnt++;
        check_cnt++; if (out_flit_valid !== 1'b0 || out_flit_data !== 32'h0 || out_flit_last !== 1'b0) $display("FAIL rstmid_out: got v%b d%h l%b want v0 d0 l0", out_flit_valid, out_flit_data, out_flit_last); else pass_cnt++;
        clear_flits();
        rst_debug_n = 1'b1;
        tick();
        check_cnt++; if (grant_id !== 2'd0 || enable_o !== 4'b0001) $display("FAIL rstmid_first_grant: got id%0d en%b want id0 en0001", grant_id, enable_o); else pass_cnt++;
        check_cnt++; if (proto_err !== 1'b0) $display("FAIL rstmid_proto_err: got %b want 0", proto_err); else pass_cnt++;
        req_i = 4'b0000;
        tick();
        tick();
    endtask

    initial begin
        rst_debug_n = 1'b0;
        arb_en = 1'b0;
        req_i = '0;
        clear_flits();
        test_reset();
        test_single();
        test_round_robin();
        test_empty_grant();
        test_abandoned();
        test_intrusion();
        test_stall();
        test_arb_en();
        test_reset_mid_packet();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
